mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 4:1 data mux between four requesters.

---
 rtl/mux4_rr_arbiter_pkg.sv | 30 +++
 rtl/mux4_rr_arbiter_if.sv | 28 ++
 rtl/mux4_rr_arbiter_mux4_w.sv | 22 ++
 rtl/mux4_rr_arbiter.sv | 94 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the four-source round-robin arbiter.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Returns {found, idx}. The search starts at ptr and wraps 3->0.
    // The first set request bit on that path wins.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req,
                                           input logic [1:0]       ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Source/sink bundle for the arbiter.
// master = the sources and the sink; slave = the arbiter.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [WIDTH-1:0] d4;
    logic             y_ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [CNT_W-1:0] xfer_cnt;

    modport master (
        output req, d1, d2, d3, d4, y_ready,
        input  gnt, sel, y, y_valid, xfer_cnt
    );

    modport slave (
        input  req, d1, d2, d3, d4, y_ready,
        output gnt, sel, y, y_valid, xfer_cnt
    );
endinterface

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// Parameterized-width 4:1 data mux.
module mux4_w #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic [WIDTH-1:0] D4,
    output logic [WIDTH-1:0] Y
);
    // Select one source by index.
    always_comb begin
        Y = D1;
        case (S)
            2'd0:    Y = D1;
            2'd1:    Y = D2;
            2'd2:    Y = D3;
            default: Y = D4;
        endcase
    end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 mux between four requesters.
// Grants are registered. y_valid follows the granted request combinationally.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mux4_rr_arbiter_if.slave   bus
);

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       sel_q;
    logic [3:0]       gnt_q;
    logic [CNT_W-1:0] cnt_q;

    logic             y_valid_c;
    logic             xfer;
    logic [1:0]       search_base;
    logic [2:0]       pick;
    logic [3:0]       pick_onehot;
    logic [WIDTH-1:0] y_mux;

    // Handshake and arbitration.
    // A completed beat moves the search start past the current winner in the
    // same cycle. This lets the next grant land with no idle cycle in between.
    always_comb begin
        y_valid_c   = (state == GRANT) && bus.req[sel_q];
        xfer        = y_valid_c && bus.y_ready;
        search_base = xfer ? (sel_q + 2'd1) : ptr;
        pick        = rr_pick(bus.req, search_base);
        pick_onehot = 4'b0001 << pick[1:0];
    end

    // FSM, priority pointer, grant registers and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
            gnt_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick[2]) begin
                        sel_q <= pick[1:0];
                        gnt_q <= pick_onehot;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        ptr   <= sel_q + 2'd1;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (pick[2]) begin
                            sel_q <= pick[1:0];
                            gnt_q <= pick_onehot;
                        end else begin
                            gnt_q <= '0;
                            state <= IDLE;
                        end
                    end else if (!bus.req[sel_q]) begin
                        gnt_q <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    mux4_w #(.WIDTH(WIDTH)) u_mux (
        .S  (sel_q),
        .D1 (bus.d1),
        .D2 (bus.d2),
        .D3 (bus.d3),
        .D4 (bus.d4),
        .Y  (y_mux)
    );

    assign bus.gnt      = gnt_q;
    assign bus.sel      = sel_q;
    assign bus.y        = y_mux;
    assign bus.y_valid  = y_valid_c;
    assign bus.xfer_cnt = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed test for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mux4_rr_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux4_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] fair_exp [5];

    initial begin
        errors  = 0;
        checks  = 0;
        // ptr is 3 when the fairness step starts, so the rotation begins at source 3.
        fair_exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // 1. Reset with every source requesting.
        rst_n       = 1'b0;
        bus.req     = 4'hF;
        bus.d1      = 8'h11;
        bus.d2      = 8'h22;
        bus.d3      = 8'h33;
        bus.d4      = 8'h44;
        bus.y_ready = 1'b0;
        #1;
        chk("rst_gnt",     32'(bus.gnt),      32'h0);
        chk("rst_y_valid", 32'(bus.y_valid),  32'h0);
        chk("rst_sel",     32'(bus.sel),      32'h0);
        chk("rst_cnt",     32'(bus.xfer_cnt), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'h0;
        @(negedge clk);
        chk("idle_gnt", 32'(bus.gnt), 32'h0);

        // 2. Single requester.
        bus.req     = 4'b0100;
        bus.d3      = 8'hA5;
        bus.y_ready = 1'b1;
        @(negedge clk);
        chk("single_gnt",     32'(bus.gnt),     32'h4);
        chk("single_sel",     32'(bus.sel),     32'h2);
        chk("single_y",       32'(bus.y),       32'hA5);
        chk("single_y_valid", 32'(bus.y_valid), 32'h1);
        @(negedge clk);
        chk("single_cnt",   32'(bus.xfer_cnt), 32'h1);
        chk("single_regnt", 32'(bus.gnt),      32'h4);
        bus.req = 4'b0000;
        #1;
        chk("single_drop_valid", 32'(bus.y_valid), 32'h0);
        @(negedge clk);
        chk("single_idle_gnt", 32'(bus.gnt),      32'h0);
        chk("single_idle_cnt", 32'(bus.xfer_cnt), 32'h1);

        // 3. Fairness with all sources requesting and the sink always ready.
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("fair_gnt%0d", i),   32'(bus.gnt),     32'(fair_exp[i]));
            chk($sformatf("fair_valid%0d", i), 32'(bus.y_valid), 32'h1);
        end
        bus.req     = 4'h0;
        bus.y_ready = 1'b0;
        @(negedge clk);
        chk("fair_idle_gnt", 32'(bus.gnt),      32'h0);
        chk("fair_cnt",      32'(bus.xfer_cnt), 32'h5);

        // 4. Backpressure. ptr is 3, so source 0 wins first.
        bus.req = 4'b0011;
        bus.d1  = 8'h11;
        bus.d2  = 8'h22;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_gnt%0d", i),   32'(bus.gnt),     32'h1);
            chk($sformatf("bp_y%0d", i),     32'(bus.y),       32'h11);
            chk($sformatf("bp_valid%0d", i), 32'(bus.y_valid), 32'h1);
        end
        bus.y_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_gnt", 32'(bus.gnt),      32'h2);
        chk("bp_next_sel", 32'(bus.sel),      32'h1);
        chk("bp_next_y",   32'(bus.y),        32'h22);
        chk("bp_cnt",      32'(bus.xfer_cnt), 32'h6);

        // 5. Withdraw while source 1 is granted.
        bus.y_ready = 1'b0;
        bus.req     = 4'b0001;
        #1;
        chk("wd_valid_now", 32'(bus.y_valid), 32'h0);
        chk("wd_gnt_now",   32'(bus.gnt),     32'h2);
        @(negedge clk);
        chk("wd_idle_gnt", 32'(bus.gnt),      32'h0);
        chk("wd_cnt",      32'(bus.xfer_cnt), 32'h6);
        // ptr stays at 1, so source 1 beats source 0.
        bus.req = 4'b0011;
        @(negedge clk);
        chk("wd_ptr_gnt", 32'(bus.gnt), 32'h2);
        chk("wd_ptr_sel", 32'(bus.sel), 32'h1);

        // 6a. Asynchronous reset in the middle of GRANT.
        rst_n = 1'b0;
        #1;
        chk("arst_gnt",   32'(bus.gnt),      32'h0);
        chk("arst_valid", 32'(bus.y_valid),  32'h0);
        chk("arst_sel",   32'(bus.sel),      32'h0);
        chk("arst_cnt",   32'(bus.xfer_cnt), 32'h0);

        // 6b. The counter wraps after 256 transfers from the sole requester.
        @(negedge clk);
        rst_n       = 1'b1;
        bus.req     = 4'b0001;
        bus.y_ready = 1'b1;
        @(negedge clk);
        chk("wrap_start_gnt", 32'(bus.gnt),      32'h1);
        chk("wrap_start_cnt", 32'(bus.xfer_cnt), 32'h0);
        repeat (255) @(negedge clk);
        chk("wrap_cnt_ff", 32'(bus.xfer_cnt), 32'hFF);
        @(negedge clk);
        chk("wrap_cnt_0", 32'(bus.xfer_cnt), 32'h0);
        chk("wrap_gnt",   32'(bus.gnt),      32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
